tran_switch_sched: RTL

Break-before-make scheduler for a shared bidirectional net built from tranif-style switches. Each of N_REQ requesters reaches the common net through its own switch enable and its own driver enable. The block grants one requester at a time with round-robin fairness and sequences each handover: switch on, then driver on, then driver off, then switch off, then a dead time. This guarantees that two drivers never meet on the net, so the net never resolves to X through contention.

---
 rtl/tran_switch_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tran_switch_sched.sv
// Break-before-make round-robin scheduler for a shared switched net.
// Sequences switch-on, driver-on, driver-off, switch-off and dead time per owner.
module tran_switch_sched #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DEAD_CYC = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic                       kill,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           sw_en,
  output logic [N_REQ-1:0]           drv_en,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy
);

  localparam int unsigned OW       = $clog2(N_REQ);
  localparam int unsigned HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam int unsigned HW       = (HOLD_LIM > 0) ? $clog2(HOLD_LIM + 1) : 1;
  localparam int unsigned DW       = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAKE,
    S_OWN,
    S_BREAK,
    S_DEAD
  } state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     rr_ptr, rr_d;
  logic [HW-1:0]     hold_cnt, hold_d;
  logic [DW-1:0]     dead_cnt, dead_d;
  logic [N_REQ-1:0]  gnt_d, sw_d, drv_d;
  logic [OW-1:0]     owner_d;
  logic              busy_d;

  logic [N_REQ-1:0]  own_oh, pick_oh;
  logic [OW-1:0]     pick_idx, cand;
  logic              pick_found;
  logic              preempt;

  assign own_oh  = N_REQ'(1) << owner;
  assign pick_oh = N_REQ'(1) << pick_idx;
  assign preempt = (MAX_HOLD != 0) && (hold_cnt == HW'(HOLD_LIM)) && (|(req & ~own_oh));

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = OW'((32'(rr_ptr) + i) % N_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sw_d    = sw_en;
    drv_d   = drv_en;
    owner_d = owner;
    rr_d    = rr_ptr;
    hold_d  = hold_cnt;
    dead_d  = dead_cnt;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          gnt_d   = pick_oh;
          sw_d    = pick_oh;
          drv_d   = '0;
          rr_d    = OW'((32'(pick_idx) + 32'd1) % N_REQ);
          state_d = S_MAKE;
        end
      end
      S_MAKE: begin
        if (kill) begin
          gnt_d   = '0;
          drv_d   = '0;
          state_d = S_BREAK;
        end else begin
          drv_d   = own_oh;
          hold_d  = '0;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (!req[owner] || kill || preempt) begin
          gnt_d   = '0;
          drv_d   = '0;
          state_d = S_BREAK;
        end else if (hold_cnt < HW'(HOLD_LIM)) begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      S_BREAK: begin
        sw_d    = '0;
        dead_d  = DW'(DEAD_CYC - 1);
        state_d = S_DEAD;
      end
      S_DEAD: begin
        if (dead_cnt == '0) begin
          state_d = S_IDLE;
        end else begin
          dead_d = dead_cnt - DW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        sw_d    = '0;
        drv_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Reset opens every switch at once; nothing is left driving the net.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt      <= '0;
      sw_en    <= '0;
      drv_en   <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      dead_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      sw_en    <= sw_d;
      drv_en   <= drv_d;
      owner    <= owner_d;
      rr_ptr   <= rr_d;
      hold_cnt <= hold_d;
      dead_cnt <= dead_d;
      busy     <= busy_d;
    end
  end

endmodule
